// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment capture monitor.
// Segment bit order is bit6..0 = m,lt,lb,b,rb,rt,t, active low.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_PAT = 16;

  // All segments off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Segment pattern for each hex digit, indexed by nibble value.
  localparam logic [SEG_W-1:0] SEG_PAT [NUM_PAT] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } stateT;

  // Decoder result for one segment pattern.
  typedef struct packed {
    logic             hit;
    logic             blank;
    logic [NIB_W-1:0] nibble;
  } decT;

endpackage

// File: rtl/seg7_pattern_dec.sv
// seg7_pattern_dec: combinational inverse of the hex-to-segment decoder.
// hit=1 for one of the 16 hex patterns, blank=1 for all segments off.
import seg7_pkg::*;

module seg7_pattern_dec (
  input  logic [SEG_W-1:0] pattern,
  output decT              result
);

  // Table search; the 16 patterns are distinct so at most one matches.
  always_comb begin
    result       = '0;
    result.blank = (pattern == SEG_BLANK);
    for (int i = 0; i < int'(NUM_PAT); i++) begin
      if (pattern == SEG_PAT[i]) begin
        result.hit    = 1'b1;
        result.nibble = NIB_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed common-anode 7-segment bus, waits for
// each pattern to settle, and decodes it back to a hex nibble per digit.
// Optional macro SEG7_CAPTURE_TIMEOUT_EN adds per-digit refresh timeouts.
import seg7_pkg::*;

module seg7_capture #(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [SEG_W-1:0]      iSEG,
  input  logic [NDIG-1:0]       iAN,
  input  logic                  iERR_CLR,
  output logic [NIB_W*NDIG-1:0] oDIG,
  output logic [NDIG-1:0]       oVLD,
  output logic [NDIG-1:0]       oBLANK,
  output logic                  oUPD,
  output logic                  oERR
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
  localparam int unsigned IDX_W = $clog2(NDIG);
  localparam int unsigned LC_W  = $clog2(NDIG + 1);

  logic [SEG_W-1:0] rSeg;
  logic [NDIG-1:0]  rAn;
  logic [CNT_W-1:0] cnt;
  stateT            state;
  logic             inChange;

  logic [LC_W-1:0]  lowCount;
  logic [IDX_W-1:0] digIdx;
  logic             oneHot;

  decT              dec;
  logic [NIB_W-1:0] digMem [NDIG];
  logic [NIB_W-1:0] newNib;
  logic             newVld;
  logic             newBlank;
  logic             newErr;
  logic             commitChg;

  // The registered pair changes on this edge when the inputs differ from it.
  assign inChange = ({iSEG, iAN} != {rSeg, rAn});

  // Input registers, stability counter and capture FSM.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rSeg  <= SEG_BLANK;
      rAn   <= '1;
      cnt   <= '0;
      state <= ST_SETTLE;
    end else begin
      rSeg <= iSEG;
      rAn  <= iAN;
      if (inChange) begin
        cnt   <= CNT_W'(1);
        state <= ST_SETTLE;
      end else begin
        if (cnt != CNT_W'(STABLE_CYC)) cnt <= cnt + CNT_W'(1);
        case (state)
          ST_SETTLE: if (cnt == CNT_W'(STABLE_CYC) && oneHot) state <= ST_COMMIT;
          ST_COMMIT: state <= ST_HOLD;
          ST_HOLD:   state <= ST_HOLD;
          default:   state <= ST_SETTLE;
        endcase
      end
    end
  end

  // Count low digit selects and locate the selected digit.
  always_comb begin
    lowCount = '0;
    digIdx   = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (!rAn[k]) begin
        lowCount = lowCount + LC_W'(1);
        digIdx   = IDX_W'(k);
      end
    end
  end

  assign oneHot = (lowCount == LC_W'(1));

  seg7_pattern_dec uDec (
    .pattern (rSeg),
    .result  (dec)
  );

  // Field values a commit would write for the selected digit.
  always_comb begin
    newVld    = dec.hit;
    newBlank  = dec.blank;
    newErr    = !dec.hit && !dec.blank;
    newNib    = dec.hit ? dec.nibble : digMem[digIdx];
    commitChg = (newNib != digMem[digIdx]) || (newVld != oVLD[digIdx]) ||
                (newBlank != oBLANK[digIdx]);
  end

`ifdef SEG7_CAPTURE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] toCnt [NDIG];
`else
  // Timeout length only matters when the refresh counters are built.
  if (TIMEOUT_CYC == 0) begin : gNoTimeout
  end
`endif

  // Per-digit storage, update pulse, sticky error and refresh timeouts.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int k = 0; k < int'(NDIG); k++) digMem[k] <= '0;
      oVLD   <= '0;
      oBLANK <= '0;
      oUPD   <= 1'b0;
      oERR   <= 1'b0;
`ifdef SEG7_CAPTURE_TIMEOUT_EN
      for (int k = 0; k < int'(NDIG); k++) toCnt[k] <= '0;
`endif
    end else begin
      oUPD <= 1'b0;
      if (state == ST_COMMIT) begin
        digMem[digIdx] <= newNib;
        oVLD[digIdx]   <= newVld;
        oBLANK[digIdx] <= newBlank;
        oUPD           <= commitChg;
      end
      if (state == ST_COMMIT && newErr) oERR <= 1'b1;
      else if (iERR_CLR)                oERR <= 1'b0;
`ifdef SEG7_CAPTURE_TIMEOUT_EN
      for (int k = 0; k < int'(NDIG); k++) begin
        if (state == ST_COMMIT && digIdx == IDX_W'(k)) begin
          toCnt[k] <= '0;
        end else if (toCnt[k] != TO_W'(TIMEOUT_CYC)) begin
          toCnt[k] <= toCnt[k] + TO_W'(1);
          if (toCnt[k] == TO_W'(TIMEOUT_CYC - 1)) begin
            oVLD[k]   <= 1'b0;
            oBLANK[k] <= 1'b0;
            if (oVLD[k] || oBLANK[k]) oUPD <= 1'b1;
          end
        end
      end
`endif
    end
  end

  // Flatten digit storage onto the output bus.
  for (genvar k = 0; k < int'(NDIG); k++) begin : gDig
    assign oDIG[NIB_W*k +: NIB_W] = digMem[k];
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed stimulus against a run-length model of the
// capture rules, compared every cycle, plus literal spot checks.
`timescale 1ns/1ps

module tb_seg7_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;
`ifdef SEG7_CAPTURE_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  localparam logic [6:0] PATS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [6:0]  iSEG = 7'h7F;
  logic [3:0]  iAN  = 4'hF;
  logic        iERR_CLR = 1'b0;
  logic [15:0] oDIG;
  logic [3:0]  oVLD, oBLANK;
  logic        oUPD, oERR;

  int nChk = 0;
  int nPass = 0;
  int updCount = 0;

  seg7_capture #(.NDIG(NDIG), .STABLE_CYC(STABLE), .TIMEOUT_CYC(TO)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSEG(iSEG), .iAN(iAN), .iERR_CLR(iERR_CLR),
    .oDIG(oDIG), .oVLD(oVLD), .oBLANK(oBLANK), .oUPD(oUPD), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int patIdx(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (s == PATS[i]) return i;
    return -1;
  endfunction

  // Model: a value captured unchanged on STABLE+1 edges is committed on the next edge.
  int         mDig [NDIG];
  int         mAge [NDIG];
  logic [3:0] mVld, mBlank;
  logic       mUpd, mErr;
  logic [10:0] mHeld;
  int         mRun;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int k = 0; k < NDIG; k++) begin mDig[k] = 0; mAge[k] = 0; end
      mVld = '0; mBlank = '0; mUpd = 1'b0; mErr = 1'b0;
      mHeld = {7'h7F, 4'hF}; mRun = 0;
    end else begin
      int  zeros, k, p, nd;
      logic nv, nb, setErr;
      logic [NDIG-1:0] committed;
      mUpd = 1'b0; setErr = 1'b0; committed = '0;
      zeros = 0; k = 0;
      for (int j = 0; j < NDIG; j++) if (!mHeld[j]) begin zeros++; k = j; end
      if (mRun == STABLE + 1 && zeros == 1) begin
        p  = patIdx(mHeld[10:4]);
        nv = (p >= 0);
        nb = (mHeld[10:4] == 7'h7F);
        nd = nv ? p : mDig[k];
        if (nd != mDig[k] || nv != mVld[k] || nb != mBlank[k]) mUpd = 1'b1;
        mDig[k] = nd; mVld[k] = nv; mBlank[k] = nb;
        committed[k] = 1'b1;
        if (!nv && !nb) setErr = 1'b1;
      end
`ifdef SEG7_CAPTURE_TIMEOUT_EN
      for (int j = 0; j < NDIG; j++) begin
        if (committed[j]) mAge[j] = 0;
        else if (mAge[j] < TO) begin
          mAge[j]++;
          if (mAge[j] == TO) begin
            if (mVld[j] || mBlank[j]) mUpd = 1'b1;
            mVld[j] = 1'b0; mBlank[j] = 1'b0;
          end
        end
      end
`endif
      if (setErr) mErr = 1'b1;
      else if (iERR_CLR) mErr = 1'b0;
      if ({iSEG, iAN} == mHeld) begin
        if (mRun < STABLE + 2) mRun++;
      end else begin
        mHeld = {iSEG, iAN};
        mRun  = 1;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge iCLK) begin
    chk("oDIG",   32'(oDIG),   32'({mDig[3][3:0], mDig[2][3:0], mDig[1][3:0], mDig[0][3:0]}));
    chk("oVLD",   32'(oVLD),   32'(mVld));
    chk("oBLANK", 32'(oBLANK), 32'(mBlank));
    chk("oUPD",   32'(oUPD),   32'(mUpd));
    chk("oERR",   32'(oERR),   32'(mErr));
    if (oUPD) updCount++;
  end

  task automatic drive(input logic [6:0] seg, input logic [3:0] an, input logic clr, input int n);
    iSEG = seg; iAN = an; iERR_CLR = clr;
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  task automatic scan();
    logic [3:0] an;
    for (int d = 0; d < 4; d++) begin
      an = 4'hF; an[d] = 1'b0;
      drive(PATS[d], an, 1'b0, 8);
      drive(7'h00, an, 1'b0, 1);
    end
  endtask

  initial begin
    int base;
    #1 iRST = 1'b1;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    chk("reset_vld", 32'(oVLD), 32'h0);
    chk("reset_dig", 32'(oDIG), 32'h0);
    iRST = 1'b0;

    // Single digit commit.
    base = updCount;
    drive(7'h24, 4'b1110, 1'b0, 10);
    chk("t1_dig0",  32'(oDIG[3:0]), 32'h2);
    chk("t1_vld",   32'(oVLD), 32'h1);
    chk("t1_upd",   32'(updCount - base), 32'd1);
    chk("t1_err",   32'(oERR), 32'h0);
    chk("t1_model", 32'(mVld), 32'h1);

    // Four-digit scan with one-cycle glitches.
    base = updCount;
    scan();
    chk("t2_dig",   32'(oDIG), 32'h3210);
    chk("t2_vld",   32'(oVLD), 32'hF);
    chk("t2_upd",   32'(updCount - base), 32'd4);

    // Identical rescans and a multi-select hold produce no updates.
    base = updCount;
    scan();
    scan();
    chk("t3_rescan_upd", 32'(updCount - base), 32'd0);
    drive(7'h79, 4'b1100, 1'b0, 10);
    chk("t3_multi_upd", 32'(updCount - base), 32'd0);
    chk("t3_multi_dig", 32'(oDIG), 32'h3210);

    // Unrecognised pattern, error clear, and clear coincident with a new error.
    drive(7'h55, 4'b1011, 1'b0, 8);
    chk("t4_vld2",   32'(oVLD[2]), 32'h0);
    chk("t4_blank2", 32'(oBLANK[2]), 32'h0);
    chk("t4_dig2",   32'(oDIG[11:8]), 32'h2);
    chk("t4_err",    32'(oERR), 32'h1);
    drive(7'h55, 4'b1011, 1'b1, 1);
    drive(7'h55, 4'b1011, 1'b0, 2);
    chk("t4_err_clr", 32'(oERR), 32'h0);
    drive(7'h11, 4'b0111, 1'b0, STABLE + 1);
    drive(7'h11, 4'b0111, 1'b1, 1);
    drive(7'h11, 4'b0111, 1'b0, 2);
    chk("t4_err_set_wins", 32'(oERR), 32'h1);
    chk("t4_vld", 32'(oVLD), 32'b0011);

    // Blank digit, then asynchronous reset during settle.
    drive(7'h7F, 4'b1101, 1'b0, 8);
    chk("t5_blank1", 32'(oBLANK[1]), 32'h1);
    chk("t5_vld1",   32'(oVLD[1]), 32'h0);
    chk("t5_dig",    32'(oDIG), 32'h3210);
    drive(7'h19, 4'b1110, 1'b0, 2);
    #3 iRST = 1'b1;
    #1;
    chk("rst_async_dig",   32'(oDIG), 32'h0);
    chk("rst_async_vld",   32'(oVLD), 32'h0);
    chk("rst_async_blank", 32'(oBLANK), 32'h0);
    chk("rst_async_err",   32'(oERR), 32'h0);
    @(posedge iCLK); #1;
    iSEG = 7'h7F; iAN = 4'hF;
    iRST = 1'b0;
    base = updCount;
    drive(7'h7F, 4'hF, 1'b0, 10);
    chk("rst_no_commit_vld", 32'(oVLD), 32'h0);
    chk("rst_no_commit_upd", 32'(updCount - base), 32'd0);

`ifdef SEG7_CAPTURE_TIMEOUT_EN
    // Stalled scan: digit 0 times out.
    drive(7'h19, 4'b1110, 1'b0, 8);
    chk("to_vld_before", 32'(oVLD[0]), 32'h1);
    base = updCount;
    drive(7'h7F, 4'hF, 1'b0, TO + 5);
    chk("to_vld_after", 32'(oVLD[0]), 32'h0);
    chk("to_upd",       32'(updCount - base), 32'd1);
`endif

    @(negedge iCLK); #1;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side monitor for the multiplexed common-anode 7-segment display bus: it is the inverse of the hex-to-segment decoder.
- Samples the active-low segment lines and the active-low digit-select lines, filters out ghosting while the scan switches digits, and decodes each stable pattern back to a hex nibble per digit.
- Used for on-board self-check of the calculator display path and as a scoreboard tap in system benches.

Parameters:
- NDIG, 4: number of multiplexed digits (2..8).
- STABLE_CYC, 4: consecutive registered cycles a pattern must hold before commit (>=2).
- TIMEOUT_CYC, 65535: refresh timeout in cycles; used only with the optional feature.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-high reset
- iSEG  in  7  segment lines, active low, bit6..0 = m,lt,lb,b,rb,rt,t
- iAN  in  NDIG  digit selects, active low, one-hot when valid
- iERR_CLR  in  1  clears oERR
- oDIG  out  4*NDIG  decoded nibble per digit; digit k at [4k+3:4k]
- oVLD  out  NDIG  digit k holds a recognised hex pattern
- oBLANK  out  NDIG  digit k last committed all-off (7'h7F)
- oUPD  out  1  one-cycle pulse: a commit changed some oDIG/oVLD/oBLANK bit
- oERR  out  1  sticky: an unrecognised pattern was committed

Behaviour:
- Reset: asynchronous, active-high. All outputs 0; input registers load iSEG=7'h7F and iAN=all-ones; counter 0; FSM in ST_SETTLE.
- Input stage: iSEG and iAN are registered every cycle (r_seg, r_an). The bench drives the inputs synchronously.
- Stability counter cnt, saturating at STABLE_CYC:
  - {r_seg, r_an} differs from the previous cycle -> cnt=1, FSM goes to ST_SETTLE from any state.
  - Otherwise cnt increments.
- FSM:
  - ST_SETTLE: when cnt==STABLE_CYC and r_an is exactly one-hot low -> ST_COMMIT. If r_an is not one-hot (none or several low), stay in ST_SETTLE with no commit.
  - ST_COMMIT: lasts one cycle. Writes digit k (the index of the low bit of r_an) -> ST_HOLD.
  - ST_HOLD: wait until the pattern changes. Exactly one commit per stable episode.
- Latency: inputs held constant from edge t give updated outputs after edge t+STABLE_CYC+1.
- Decode table (r_seg -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 18->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
- Commit write:
  - Recognised pattern: oDIG[k]=nibble, oVLD[k]=1, oBLANK[k]=0.
  - 7F: oVLD[k]=0, oBLANK[k]=1, oDIG[k] retained.
  - Any other pattern: oVLD[k]=0, oBLANK[k]=0, oDIG[k] retained, oERR=1.
- oUPD: asserted in the commit cycle only if any of the three fields for digit k changed. A re-commit of an identical value gives no pulse.
- oERR and iERR_CLR: oERR is set on an unrecognised commit and cleared by iERR_CLR. If both happen in the same cycle, set wins.
- Reset mid-settle or mid-commit: everything returns to reset state immediately; a partial commit is never visible.

Optional Feature:
- Macro SEG7_CAPTURE_TIMEOUT_EN.
- Defined: each digit gets a refresh counter that clears on a commit to that digit and saturates at TIMEOUT_CYC. On reaching TIMEOUT_CYC, oVLD[k] and oBLANK[k] clear, and oUPD pulses if either was set. This detects a stalled scan.
- Undefined: no counters; committed values persist until overwritten or reset.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK=7'h7F and the 16-entry pattern constants.
  - FSM state typedef (ST_SETTLE, ST_COMMIT, ST_HOLD).
  - Width constants.
- Sub-module seg7_pattern_dec: combinational, 7-bit pattern -> {hit, blank, nibble[3:0]}. Reusable by benches.
- Top module seg7_capture holds the registers, counter, FSM, per-digit storage and the optional timeout counters.

Test Plan:
- Reset, then iAN=4'b1110, iSEG=7'h24 held 10 cycles -> after STABLE_CYC+1 edges: oDIG[3:0]=2, oVLD=4'b0001, oUPD one pulse, oERR=0.
- Scan 4 digits showing 7'h40, 7'h79, 7'h24, 7'h30 at 8 cycles each, with 1-cycle glitch patterns between digits -> oDIG=16'h3210, oVLD=4'hF, glitches never committed.
- Same pattern re-scanned twice -> second pass produces no oUPD. Hold iAN=4'b1100 with a valid iSEG -> no commit.
- iAN=4'b1011, iSEG=7'h55 stable -> oVLD[2]=0, oBLANK[2]=0, oDIG[2] retained, oERR=1. Pulse iERR_CLR -> oERR=0. iERR_CLR coincident with a new error -> oERR stays 1.
- iSEG=7'h7F on digit 1 -> oBLANK[1]=1, oVLD[1]=0. Assert iRST during ST_SETTLE -> all outputs 0 asynchronously, no commit afterwards.
- With SEG7_CAPTURE_TIMEOUT_EN and TIMEOUT_CYC=100: commit digit 0, then idle 100 cycles -> oVLD[0] clears with one oUPD pulse.
